// File: rtl/hilo_muldiv.sv
// ---------------------------------------------------------------------------
// hilo_muldiv
//   Multi-cycle multiply/divide unit owning the architectural HI/LO registers.
//   One result bit per cycle: shift-add multiply (multiplier LSB first) and
//   restoring divide. A result is written WIDTH edges after Start is accepted.
//
// Ports
//   clk    in   rising-edge clock
//   rst    in   synchronous, active-high reset
//   Start  in   one-cycle request, sampled only while Busy=0
//   Op     in   [1:0] 00 MULTU, 01 DIVU, 10 MULT, 11 DIV
//   SrcA   in   [WIDTH] multiplicand / dividend (rs)
//   SrcB   in   [WIDTH] multiplier / divisor (rt)
//   HiOut  out  [WIDTH] product upper half / remainder
//   LoOut  out  [WIDTH] product lower half / quotient
//   Busy   out  operation in progress
//   Done   out  one-cycle pulse after HI/LO were updated
//
// Build option
//   HILO_SIGNED_EN : when defined, Op 10/11 are signed MULT/DIV. When
//                    undefined, Op[1] is ignored and no sign logic exists.
// ---------------------------------------------------------------------------
module hilo_muldiv #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             Start,
    input  logic [1:0]       Op,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic [WIDTH-1:0] HiOut,
    output logic [WIDTH-1:0] LoOut,
    output logic             Busy,
    output logic             Done
);

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // Working registers, never visible on the ports
    logic               r_is_div;
    logic [WIDTH-1:0]   r_opa;      // multiplicand / divisor, constant in RUN
    logic [WIDTH-1:0]   r_opb;      // multiplier (shifts right) / dividend (shifts left)
    logic [2*WIDTH-1:0] r_acc;      // {hi, lo}: partial product, or {remainder, quotient}
    logic [CNT_W-1:0]   r_cnt;
    logic               r_done;

    // FSM controls
    logic w_load;
    logic w_finish;

    // Operand magnitudes captured at acceptance
    logic [WIDTH-1:0] w_mag_a;
    logic [WIDTH-1:0] w_mag_b;

    // Iteration datapath
    logic [WIDTH:0]     w_sum;
    logic [2*WIDTH-1:0] w_mul_acc;
    logic [WIDTH:0]     w_shrem;
    logic [WIDTH+1:0]   w_diff;
    logic               w_qbit;
    logic [2*WIDTH-1:0] w_div_acc;
    logic [2*WIDTH-1:0] w_acc_nxt;
    logic [WIDTH-1:0]   w_opb_nxt;

    // Final write values
    logic [WIDTH-1:0] w_hi_fin;
    logic [WIDTH-1:0] w_lo_fin;

`ifdef HILO_SIGNED_EN
    logic               r_neg_lo;   // negate product (mul) or quotient (div)
    logic               r_neg_hi;   // remainder takes the dividend's sign
    logic               w_sa;
    logic               w_sb;
    logic [2*WIDTH-1:0] w_prod_fix;
`else
    logic w_unused_op;
    assign w_unused_op = Op[1];
`endif

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and controls
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_finish    = 1'b0;
        Busy        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (Start) begin
                    w_load      = 1'b1;
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                Busy = 1'b1;
                if (r_cnt == CNT_W'(WIDTH - 1)) begin
                    w_finish    = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Operand conditioning
    // ------------------------------------------------------------------
`ifdef HILO_SIGNED_EN
    always_comb begin
        w_sa    = Op[1] & SrcA[WIDTH-1];
        w_sb    = Op[1] & SrcB[WIDTH-1];
        w_mag_a = w_sa ? -SrcA : SrcA;
        w_mag_b = w_sb ? -SrcB : SrcB;
    end
`else
    always_comb begin
        w_mag_a = SrcA;
        w_mag_b = SrcB;
    end
`endif

    // ------------------------------------------------------------------
    // One iteration of multiply and divide
    // ------------------------------------------------------------------
    always_comb begin
        // Multiply: add multiplicand into the upper half when the current
        // multiplier bit is set, then shift the whole accumulator right.
        w_sum     = {1'b0, r_acc[2*WIDTH-1:WIDTH]} +
                    {1'b0, (r_opb[0] ? r_opa : {WIDTH{1'b0}})};
        w_mul_acc = {w_sum, r_acc[WIDTH-1:1]};

        // Restoring divide: bring in the next dividend bit, trial-subtract.
        // The extra top bit of w_diff is the borrow (negative result).
        w_shrem   = {r_acc[2*WIDTH-1:WIDTH], r_opb[WIDTH-1]};
        w_diff    = {1'b0, w_shrem} - {2'b00, r_opa};
        w_qbit    = ~w_diff[WIDTH+1];
        w_div_acc = {(w_qbit ? w_diff[WIDTH-1:0] : w_shrem[WIDTH-1:0]),
                     r_acc[WIDTH-2:0], w_qbit};

        if (r_is_div) begin
            w_acc_nxt = w_div_acc;
            w_opb_nxt = r_opb << 1;
        end else begin
            w_acc_nxt = w_mul_acc;
            w_opb_nxt = r_opb >> 1;
        end
    end

    // ------------------------------------------------------------------
    // Result fix-up applied in the final write
    // ------------------------------------------------------------------
`ifdef HILO_SIGNED_EN
    always_comb begin
        w_prod_fix = r_neg_lo ? -w_acc_nxt : w_acc_nxt;
        if (r_is_div) begin
            w_hi_fin = r_neg_hi ? -w_acc_nxt[2*WIDTH-1:WIDTH] : w_acc_nxt[2*WIDTH-1:WIDTH];
            w_lo_fin = r_neg_lo ? -w_acc_nxt[WIDTH-1:0]       : w_acc_nxt[WIDTH-1:0];
        end else begin
            w_hi_fin = w_prod_fix[2*WIDTH-1:WIDTH];
            w_lo_fin = w_prod_fix[WIDTH-1:0];
        end
    end
`else
    always_comb begin
        w_hi_fin = w_acc_nxt[2*WIDTH-1:WIDTH];
        w_lo_fin = w_acc_nxt[WIDTH-1:0];
    end
`endif

    // ------------------------------------------------------------------
    // Datapath and architectural registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_is_div <= 1'b0;
            r_opa    <= '0;
            r_opb    <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_done   <= 1'b0;
            HiOut    <= '0;
            LoOut    <= '0;
`ifdef HILO_SIGNED_EN
            r_neg_lo <= 1'b0;
            r_neg_hi <= 1'b0;
`endif
        end else begin
            r_done <= w_finish;
            if (w_load) begin
                // r_opa holds |SrcB| (divisor, or multiplicand since the
                // product is commutative); r_opb holds |SrcA|.
                r_is_div <= Op[0];
                r_opa    <= w_mag_b;
                r_opb    <= w_mag_a;
                r_acc    <= '0;
                r_cnt    <= '0;
`ifdef HILO_SIGNED_EN
                r_neg_lo <= w_sa ^ w_sb;
                r_neg_hi <= w_sa;
`endif
            end else if (r_state == S_RUN) begin
                r_acc <= w_acc_nxt;
                r_opb <= w_opb_nxt;
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_finish) begin
                HiOut <= w_hi_fin;
                LoOut <= w_lo_fin;
            end
        end
    end

    assign Done = r_done;

endmodule

// File: tb/tb_hilo_muldiv.sv
// ---------------------------------------------------------------------------
// tb_hilo_muldiv
//   Directed self-checking bench for hilo_muldiv with hand-computed vectors.
//   Expected signed/unsigned results for Op 10/11 follow HILO_SIGNED_EN.
// ---------------------------------------------------------------------------
module tb_hilo_muldiv;

    logic        clk;
    logic        rst;
    logic        Start;
    logic [1:0]  Op;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic [31:0] HiOut;
    logic [31:0] LoOut;
    logic        Busy;
    logic        Done;

    int total;
    int bad;

    // Model of the architectural HI/LO contents
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    hilo_muldiv #(
        .WIDTH(32),
        .CNT_W(6)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .Start (Start),
        .Op    (Op),
        .SrcA  (SrcA),
        .SrcB  (SrcB),
        .HiOut (HiOut),
        .LoOut (LoOut),
        .Busy  (Busy),
        .Done  (Done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op, follow it to completion, check latency, hold and result.
    task automatic do_op(input string tag, input logic [1:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                         input bit inject);
        int n;
        bit held;
        Start = 1'b1;
        Op    = op;
        SrcA  = a;
        SrcB  = b;
        tick();
        Start = 1'b0;
        Op    = ~op;
        SrcA  = $urandom;
        SrcB  = $urandom;
        chk({tag, "_accept"}, {62'd0, Busy, Done}, 64'd2);
        n    = 0;
        held = 1'b1;
        while (Busy && n < 40) begin
            if (HiOut !== m_hi || LoOut !== m_lo || Done !== 1'b0) held = 1'b0;
            if (inject && (n == 5 || n == 20)) begin
                Start = 1'b1;
                Op    = 2'b00;
                SrcA  = 32'h0000_1234;
                SrcB  = 32'h0000_5678;
            end else begin
                Start = 1'b0;
            end
            tick();
            n++;
        end
        Start = 1'b0;
        chk({tag, "_busy_cycles"}, 64'(n), 64'd32);
        chk({tag, "_hold"}, {63'd0, held}, 64'd1);
        chk({tag, "_done"}, {63'd0, Done}, 64'd1);
        chk({tag, "_hi"}, {32'd0, HiOut}, {32'd0, exp_hi});
        chk({tag, "_lo"}, {32'd0, LoOut}, {32'd0, exp_lo});
        m_hi = exp_hi;
        m_lo = exp_lo;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        m_hi  = '0;
        m_lo  = '0;
        rst   = 1'b1;
        Start = 1'b0;
        Op    = 2'b00;
        SrcA  = '0;
        SrcB  = '0;

        // Reset, then idle stability
        tick();
        tick();
        rst = 1'b0;
        chk("rst_hi", {32'd0, HiOut}, 64'd0);
        chk("rst_lo", {32'd0, LoOut}, 64'd0);
        chk("rst_busy", {63'd0, Busy}, 64'd0);
        chk("rst_done", {63'd0, Done}, 64'd0);
        repeat (3) tick();
        chk("idle_hilo", {HiOut, LoOut}, 64'd0);
        chk("idle_ctl", {62'd0, Busy, Done}, 64'd0);

        // Basic divide, then Done drops after one cycle
        do_op("divu_100_7", 2'b01, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
        tick();
        chk("done_pulse_end", {63'd0, Done}, 64'd0);

        // Full-width multiply, old HI/LO held throughout
        do_op("multu_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
              32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        tick();

        // Unsigned divide by zero
        do_op("divu_by0", 2'b01, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b0);
        tick();

        // Start pulses during RUN are ignored
        do_op("divu_ignore", 2'b01, 32'd1000, 32'd10, 32'd0, 32'd100, 1'b1);
        // Start in the Done cycle: accepted back-to-back
        do_op("multu_b2b", 2'b00, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0);
        tick();

        // Reset in the middle of a divide
        Start = 1'b1;
        Op    = 2'b01;
        SrcA  = 32'h0000_1000;
        SrcB  = 32'd3;
        tick();
        Start = 1'b0;
        repeat (10) tick();
        chk("mid_busy", {63'd0, Busy}, 64'd1);
        rst = 1'b1;
        tick();
        chk("abort_hilo", {HiOut, LoOut}, 64'd0);
        chk("abort_ctl", {62'd0, Busy, Done}, 64'd0);
        m_hi = '0;
        m_lo = '0;
        // rst and Start together: Start dropped
        Start = 1'b1;
        Op    = 2'b01;
        SrcA  = 32'd50;
        SrcB  = 32'd5;
        tick();
        rst   = 1'b0;
        Start = 1'b0;
        chk("rst_start_busy", {63'd0, Busy}, 64'd0);
        tick();
        chk("rst_start_idle", {62'd0, Busy, Done}, 64'd0);
        do_op("divu_9_3", 2'b01, 32'd9, 32'd3, 32'd0, 32'd3, 1'b0);
        tick();

        // Op 10/11: signed with the option, unsigned aliases without
`ifdef HILO_SIGNED_EN
        do_op("mult_m2_3", 2'b10, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0);
        tick();
        do_op("div_m7_2", 2'b11, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        tick();
        do_op("div_min_m1", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0);
        tick();
        do_op("div_m5_by0", 2'b11, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'h0000_0001, 1'b0);
        tick();
        do_op("div_7_by0", 2'b11, 32'd7, 32'd0, 32'd7, 32'hFFFF_FFFF, 1'b0);
`else
        do_op("mult_m2_3", 2'b10, 32'hFFFF_FFFE, 32'd3, 32'h0000_0002, 32'hFFFF_FFFA, 1'b0);
        tick();
        do_op("div_m7_2", 2'b11, 32'hFFFF_FFF9, 32'd2, 32'h0000_0001, 32'h7FFF_FFFC, 1'b0);
        tick();
        do_op("div_min_m1", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000, 1'b0);
        tick();
        do_op("div_m5_by0", 2'b11, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b0);
`endif
        tick();
        chk("final_done_low", {63'd0, Done}, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hilo_muldiv.md
Name: hilo_muldiv

Overview:
- Multi-cycle multiply/divide unit that owns the architectural HI and LO registers.
- Sits directly upstream of the writeback result-select mux and drives its HiOut and LoOut inputs.
- The decode/EX stage issues MULTU/DIVU with a one-cycle Start pulse.
- The pipeline stalls on Busy before any MFHI/MFLO or new mul/div.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- Start  input  1  one-cycle request; sampled only when Busy=0
- Op  input  2  00 MULTU, 01 DIVU, 10 MULT, 11 DIV
- SrcA  input  WIDTH  multiplicand / dividend (rs)
- SrcB  input  WIDTH  multiplier / divisor (rt)
- HiOut  output  WIDTH  architectural HI: product upper half / remainder
- LoOut  output  WIDTH  architectural LO: product lower half / quotient
- Busy  output  1  operation in progress
- Done  output  1  one-cycle pulse when HI/LO have just been updated

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset values: HiOut=0, LoOut=0, Busy=0, Done=0, state=IDLE, counter=0.
- States:
  - IDLE: if Start, latch SrcA/SrcB/Op, clear the working accumulator, counter=0, go to RUN, Busy=1 next cycle.
  - RUN: one bit per cycle.
    - Multiply: shift-add, LSB of multiplier first, into a 2*WIDTH accumulator.
    - Divide: restoring; shift remainder left, trial-subtract divisor, set quotient bit when result is non-negative.
  - On the edge completing iteration WIDTH-1, write HiOut/LoOut, go to IDLE, Busy=0, Done=1.
- Latency: Start sampled at edge E0; results visible and Done=1 after edge E32 (WIDTH edges). Done returns to 0 after one cycle.
- HiOut/LoOut hold their previous values for the whole of RUN. Working registers are internal and never exposed.
- Start while Busy=1 is ignored: no queueing, operands not re-latched.
- Done=1 cycle with Start=1: accepted; a back-to-back op begins, with Busy=1 on the next cycle.
- Op/SrcA/SrcB changes after E0 have no effect.
- Divide by zero, unsigned: natural restoring result, Lo=all ones, Hi=dividend. No trap, no flag.
- Multiply: {HiOut,LoOut} = full 2*WIDTH product, no truncation.
- rst mid-RUN: operation aborted; all outputs return to reset values at that edge.
- rst and Start in the same cycle: rst wins, Start dropped.

Optional Feature:
- Macro: HILO_SIGNED_EN
- Defined:
  - Op 10/11 perform signed MULT/DIV. Operands are converted to magnitudes at E0.
  - Product is negated when the operand signs differ.
  - Quotient is negated when the signs differ; remainder takes the dividend's sign. Sign fix-up happens in the final write, so latency stays WIDTH.
  - 0x80000000 / 0xFFFFFFFF: Lo=0x80000000, Hi=0.
  - Signed divide by zero: Lo = 0xFFFFFFFF if dividend ≥0, else 0x00000001; Hi = dividend.
- Not defined: Op[1] is ignored; 10 behaves as MULTU and 11 as DIVU. No sign logic is synthesised.

Test Plan:
- Reset then idle: rst=1 for 2 cycles -> HiOut=0, LoOut=0, Busy=0, Done=0. Outputs stay stable with Start=0.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF, Start at E0:
  - Busy=1 for exactly 32 cycles.
  - Done pulses after E32 with Hi=0xFFFFFFFE, Lo=0x00000001.
  - Old Hi/Lo held until then.
- DIVU 100 / 7 -> Lo=14, Hi=2 after E32. Then DIVU 5 / 0 -> Lo=0xFFFFFFFF, Hi=5.
- Start pulsed at cycles 5 and 20 during RUN with different operands -> ignored, result matches the first op only.
- Start in the Done cycle (MULTU 3 × 4) -> accepted back-to-back; Hi=0, Lo=12 after 32 more edges.
- rst asserted at iteration 10 of DIVU, then Start DIVU 9 / 3 -> outputs zeroed at reset. New op yields Lo=3, Hi=0.
- HILO_SIGNED_EN defined, two cases:
  - DIV −7 / 2 -> Lo=0xFFFFFFFD (−3), Hi=0xFFFFFFFF (−1).
  - MULT −2 × 3 -> Hi=0xFFFFFFFF, Lo=0xFFFFFFFA.
